lutram_readback_checker: RTL

- Read-side companion to the LUTRAM write-pattern harnesses.
- Walks every address of a distributed-RAM primitive under test and drives its address pins.
- Samples the RAM's read data and compares it against the known write pattern, then reports pass/fail, the error count and the first failing address.
- Sits in the divided-clock test domain, between the RAM primitive and the board-level status outputs (LEDs / probe pins).

---
 rtl/lutram_readback_checker_pkg.sv | 43 ++++
 rtl/lutram_pattern_gen.sv | 20 ++
 rtl/lutram_readback_checker.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/lutram_readback_checker_pkg.sv
// Shared definitions for the LUTRAM write harnesses and the readback checker.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package lutram_test_pkg;

  // Readback checker FSM encoding.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_READ  = 2'b01,
    ST_DRAIN = 2'b10,
    ST_DONE  = 2'b11
  } chk_state_t;

  // Write-harness FSM states, shared so writer and checker agree on sequencing.
  typedef enum logic [2:0] {
    HS_INITIAL = 3'd0,
    HS_CLEAR   = 3'd1,
    HS_WRITE   = 3'd2,
    HS_READ    = 3'd3,
    HS_FINISH  = 3'd4
  } harness_state_t;

  // Data pattern selectors.
  localparam int PAT_ADDR0  = 0;  // addr[0]
  localparam int PAT_NADDR0 = 1;  // ~addr[0]
  localparam int PAT_ZERO   = 2;  // all zeros
  localparam int PAT_PARITY = 3;  // XOR-reduce of the address

  // Single pattern bit for an address; callers zero-extend the address so the
  // parity term only sees real address bits.
  function automatic logic pattern_bit(input int pattern, input logic [31:0] addr);
    logic b;
    case (pattern)
      PAT_ADDR0:  b = addr[0];
      PAT_NADDR0: b = ~addr[0];
      PAT_ZERO:   b = 1'b0;
      PAT_PARITY: b = ^addr;
      default:    b = 1'b0;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/lutram_pattern_gen.sv
// Address to expected RAM word; the pattern bit is replicated across the word.
// Latency: combinational. Backpressure: none.
// Ports: addr (RAM address in), data (expected D_WIDTH word out).
module lutram_pattern_gen
  import lutram_test_pkg::*;
#(
  parameter int A_WIDTH = 6,
  parameter int D_WIDTH = 1,
  parameter int PATTERN = PAT_ADDR0
) (
  input  logic [A_WIDTH-1:0] addr,
  output logic [D_WIDTH-1:0] data
);

  logic [31:0] addr_ext;

  assign addr_ext = 32'(addr);
  assign data     = {D_WIDTH{pattern_bit(PATTERN, addr_ext)}};

endmodule

// File: rtl/lutram_readback_checker.sv
// Walks every RAM address, compares read data with the write pattern, reports
// pass/fail, error count and first failing address.
// Latency: READ_LAT step strobes from address to compare; 2**A_WIDTH+READ_LAT
// strobes per pass. Backpressure: all state holds in cycles with step_i=0.
// Ports: clk_i/rst_i (sync active-high), start_i, step_i, addr_o -> RAM,
// q_i <- RAM, busy_o/done_o/pass_o status, err_count_o, first_err_*.
module lutram_readback_checker
  import lutram_test_pkg::*;
#(
  parameter int A_WIDTH  = 6,
  parameter int D_WIDTH  = 1,
  parameter int PATTERN  = PAT_ADDR0,
  parameter int READ_LAT = 0
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               step_i,
  output logic [A_WIDTH-1:0] addr_o,
  input  logic [D_WIDTH-1:0] q_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               pass_o,
  output logic [A_WIDTH:0]   err_count_o,
  output logic               first_err_valid_o,
  output logic [A_WIDTH-1:0] first_err_addr_o
);

  localparam logic [A_WIDTH-1:0] LAST_ADDR = {A_WIDTH{1'b1}};

  chk_state_t          state;
  logic [D_WIDTH-1:0]  exp_cur;
  logic                start_go;

  // Entry currently leaving the delay line (or the live address when READ_LAT=0).
  logic                cmp_vld;
  logic [A_WIDTH-1:0]  cmp_addr;
  logic [D_WIDTH-1:0]  cmp_exp;
  logic                mismatch;
  logic [A_WIDTH:0]    err_nxt;

  lutram_pattern_gen #(
    .A_WIDTH (A_WIDTH),
    .D_WIDTH (D_WIDTH),
    .PATTERN (PATTERN)
  ) u_pattern_gen (
    .addr (addr_o),
    .data (exp_cur)
  );

  // start_i only matters when not busy.
  assign start_go = start_i && ((state == ST_IDLE) || (state == ST_DONE));

  generate
    if (READ_LAT == 0) begin : g_async
      assign cmp_vld  = step_i && (state == ST_READ);
      assign cmp_addr = addr_o;
      assign cmp_exp  = exp_cur;
    end else begin : g_dl
      logic               step_act;
      logic               dl_vld  [READ_LAT];
      logic [A_WIDTH-1:0] dl_addr [READ_LAT];
      logic [D_WIDTH-1:0] dl_exp  [READ_LAT];

      assign step_act = step_i && ((state == ST_READ) || (state == ST_DRAIN));

      always_ff @(posedge clk_i) begin
        if (rst_i || start_go) begin
          for (int i = 0; i < READ_LAT; i++) begin
            dl_vld[i]  <= 1'b0;
            dl_addr[i] <= '0;
            dl_exp[i]  <= '0;
          end
        end else if (step_act) begin
          // DRAIN shifts in bubbles so the tail empties out behind the last address.
          dl_vld[0]  <= (state == ST_READ);
          dl_addr[0] <= addr_o;
          dl_exp[0]  <= exp_cur;
          for (int i = 1; i < READ_LAT; i++) begin
            dl_vld[i]  <= dl_vld[i-1];
            dl_addr[i] <= dl_addr[i-1];
            dl_exp[i]  <= dl_exp[i-1];
          end
        end
      end

      assign cmp_vld  = step_act && dl_vld[READ_LAT-1];
      assign cmp_addr = dl_addr[READ_LAT-1];
      assign cmp_exp  = dl_exp[READ_LAT-1];
    end
  endgenerate

  assign mismatch = cmp_vld && (q_i != cmp_exp);
  assign err_nxt  = err_count_o + {{A_WIDTH{1'b0}}, mismatch};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state             <= ST_IDLE;
      addr_o            <= '0;
      busy_o            <= 1'b0;
      done_o            <= 1'b0;
      pass_o            <= 1'b0;
      err_count_o       <= '0;
      first_err_valid_o <= 1'b0;
      first_err_addr_o  <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          // A step in the same cycle as start is deliberately not consumed.
          if (start_go) begin
            state             <= ST_READ;
            addr_o            <= '0;
            busy_o            <= 1'b1;
            done_o            <= 1'b0;
            pass_o            <= 1'b0;
            err_count_o       <= '0;
            first_err_valid_o <= 1'b0;
            first_err_addr_o  <= '0;
          end
        end

        ST_READ: begin
          if (step_i) begin
            err_count_o <= err_nxt;
            if (mismatch && !first_err_valid_o) begin
              first_err_valid_o <= 1'b1;
              first_err_addr_o  <= cmp_addr;
            end
            if (addr_o == LAST_ADDR) begin
              addr_o <= '0;
              if (READ_LAT == 0) begin
                state  <= ST_DONE;
                busy_o <= 1'b0;
                done_o <= 1'b1;
                pass_o <= (err_nxt == '0);
              end else begin
                state <= ST_DRAIN;
              end
            end else begin
              addr_o <= addr_o + 1'b1;
            end
          end
        end

        ST_DRAIN: begin
          if (step_i) begin
            err_count_o <= err_nxt;
            if (mismatch && !first_err_valid_o) begin
              first_err_valid_o <= 1'b1;
              first_err_addr_o  <= cmp_addr;
            end
            // The pass ends when the last address leaves the delay line,
            // which is exactly READ_LAT steps after entering DRAIN.
            if (cmp_vld && (cmp_addr == LAST_ADDR)) begin
              state  <= ST_DONE;
              busy_o <= 1'b0;
              done_o <= 1'b1;
              pass_o <= (err_nxt == '0);
            end
          end
        end

        default: begin
          state             <= ST_IDLE;
          addr_o            <= '0;
          busy_o            <= 1'b0;
          done_o            <= 1'b0;
          pass_o            <= 1'b0;
          err_count_o       <= '0;
          first_err_valid_o <= 1'b0;
          first_err_addr_o  <= '0;
        end
      endcase
    end
  end

endmodule
